// File: rtl/defs.sv
// Parameters and the global phase type shared across the solver pipeline.
package defs;
  localparam int unsigned GRID_ADDRWIDTH = 4;
  localparam int unsigned CWIDTH         = 16;

  typedef enum logic [1:0] {
    SCATTER = 2'd0,
    SOLVE   = 2'd1,
    GATHER  = 2'd2,
    PUSH    = 2'd3
  } step_t;
endpackage

// File: rtl/charge_gather.sv
// Sweeps the charge grid in even/odd block pairs and streams the returned sums
// to the solver over AXI-stream, with a credit-guarded FIFO absorbing read latency.
module charge_gather #(
  parameter int unsigned GRID_ADDRWIDTH = defs::GRID_ADDRWIDTH,
  parameter int unsigned CWIDTH         = defs::CWIDTH,
  parameter int unsigned LATENCY        = 7,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  defs::step_t                         step,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                valid_req,
  output logic [1:0][GRID_ADDRWIDTH-1:0]      grid_addr_out,
  input  logic [1:0][3:0][CWIDTH-1:0]         charge_in,
  output logic                                m_tvalid,
  input  logic                                m_tready,
  output logic                                m_tlast,
  output logic [8*CWIDTH-1:0]                 m_tdata,
  output logic [GRID_ADDRWIDTH-2:0]           m_tuser
);
  localparam int unsigned KW = GRID_ADDRWIDTH - 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = 8 * CWIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state, state_n;
  logic [KW-1:0]   k, k_n;
  logic            issue_c, abort_c, push_c, pop_c, credit_c;
  logic [CW-1:0]   fifo_count, fifo_count_n, inflight;
  logic [KW-1:0]   req_k;
  logic [LATENCY-1:0] sr_v;
  logic [KW-1:0]   sr_k [LATENCY];
  logic [DW-1:0]   mem_d [FIFO_DEPTH];
  logic [KW-1:0]   mem_k [FIFO_DEPTH];
  logic            mem_l [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;

  // A request may only go out if its eventual capture is guaranteed a FIFO slot.
  assign credit_c     = ((CW+1)'(fifo_count) + (CW+1)'(inflight)) < (CW+1)'(FIFO_DEPTH);
  assign push_c       = sr_v[LATENCY-1];
  assign pop_c        = m_tvalid && m_tready;
  assign fifo_count_n = fifo_count + CW'(push_c) - CW'(pop_c);

  assign m_tdata = mem_d[rd_ptr];
  assign m_tuser = mem_k[rd_ptr];
  assign m_tlast = mem_l[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
    end
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    issue_c = 1'b0;
    abort_c = 1'b0;
    case (state)
      IDLE: begin
        k_n = '0;
        if (start && step == defs::SOLVE) state_n = ISSUE;
      end
      ISSUE: begin
        if (step != defs::SOLVE) begin
          abort_c = 1'b1;
          state_n = IDLE;
        end else if (credit_c) begin
          issue_c = 1'b1;
          k_n     = k + KW'(1);
          if (k == {KW{1'b1}}) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (step != defs::SOLVE) begin
          abort_c = 1'b1;
          state_n = IDLE;
        end else if (pop_c && m_tlast && fifo_count == CW'(1) && inflight == '0) begin
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request issue, latency shift register and the beat FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      valid_req     <= 1'b0;
      grid_addr_out <= '0;
      req_k         <= '0;
      sr_v          <= '0;
      inflight      <= '0;
      fifo_count    <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      m_tvalid      <= 1'b0;
      for (int i = 0; i < LATENCY; i++) sr_k[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_d[i] <= '0;
        mem_k[i] <= '0;
        mem_l[i] <= 1'b0;
      end
    end else begin
      busy      <= (state_n == ISSUE) || (state_n == DRAIN);
      done      <= (state_n == DONE);
      valid_req <= issue_c;
      if (issue_c) begin
        grid_addr_out[0] <= {k, 1'b0};
        grid_addr_out[1] <= {k, 1'b1};
        req_k            <= k;
      end
      if (abort_c) begin
        sr_v       <= '0;
        inflight   <= '0;
        fifo_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        m_tvalid   <= 1'b0;
      end else begin
        // The registered request enters the pipe so its tail lines up with charge_in.
        sr_v[0] <= valid_req;
        sr_k[0] <= req_k;
        for (int i = 1; i < LATENCY; i++) begin
          sr_v[i] <= sr_v[i-1];
          sr_k[i] <= sr_k[i-1];
        end
        inflight   <= inflight + CW'(issue_c) - CW'(push_c);
        fifo_count <= fifo_count_n;
        m_tvalid   <= (fifo_count_n != '0);
        if (push_c) begin
          mem_d[wr_ptr] <= charge_in;
          mem_k[wr_ptr] <= sr_k[LATENCY-1];
          mem_l[wr_ptr] <= (sr_k[LATENCY-1] == {KW{1'b1}});
          wr_ptr        <= wr_ptr + PW'(1);
        end
        if (pop_c) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end
endmodule
